// File: rtl/dmem_pkg.sv
// Shared types and helpers for the RV64 data memory: access size encoding,
// controller states and the read-pipeline stage payload.
package dmem_pkg;

    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2,
        SZ_D = 2'd3
    } size_e;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_e;

    typedef struct packed {
        logic        err;
        size_e       size;
        logic        uns;
        logic [63:0] raw;
    } rd_stage_t;

    // Byte count minus one; doubles as the low-address alignment mask.
    function automatic logic [2:0] size_mask(input size_e size);
        case (size)
            SZ_B:    return 3'd0;
            SZ_H:    return 3'd1;
            SZ_W:    return 3'd3;
            default: return 3'd7;
        endcase
    endfunction

    function automatic logic is_misaligned(input logic [2:0] addr_lo, input size_e size);
        return |(addr_lo & size_mask(size));
    endfunction

endpackage

// File: rtl/dmem_if.sv
// Request/response bus between the MEM stage (master) and the data memory (slave).
interface dmem_if;
    import dmem_pkg::*;

    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    size_e       req_size;
    logic        req_unsigned;
    logic [63:0] req_addr;
    logic [63:0] req_wdata;
    logic        rsp_valid;
    logic [63:0] rsp_rdata;
    logic        rsp_err;

    modport master (
        output req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );

endinterface

// File: rtl/dmem_load_extend.sv
// Sign/zero extension of a right-justified load datum to 64 bits.
module dmem_load_extend
    import dmem_pkg::*;
(
    input  logic [63:0] raw_i,
    input  size_e       size_i,
    input  logic        unsigned_i,
    output logic [63:0] ext_o
);

    always_comb begin
        ext_o = raw_i;
        case (size_i)
            SZ_B:    ext_o = {{56{raw_i[7]  & ~unsigned_i}}, raw_i[7:0]};
            SZ_H:    ext_o = {{48{raw_i[15] & ~unsigned_i}}, raw_i[15:0]};
            SZ_W:    ext_o = {{32{raw_i[31] & ~unsigned_i}}, raw_i[31:0]};
            default: ext_o = raw_i;
        endcase
    end

endmodule

// File: rtl/dmem_ctrl.sv
// Handshaked RV64 data memory with post-reset clear sweep and configurable read latency.
// Define DMEM_PROBE_EN to build the registered probe taps; otherwise probe_data is 0.
module dmem_ctrl
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH_BYTES  = 512,
    parameter int unsigned READ_LATENCY = 1,
    parameter int unsigned NUM_PROBES   = 4,
    parameter int unsigned PROBE_BASE   = 256,
    parameter int unsigned PROBE_STRIDE = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    dmem_if.slave                   bus,
    output logic [8*NUM_PROBES-1:0] probe_data
);

    localparam int unsigned WORDS = DEPTH_BYTES / 8;
    localparam int unsigned WAW   = (WORDS > 1) ? $clog2(WORDS) : 1;

    state_e         state_q, state_d;
    logic [WAW-1:0] clear_ptr_q, clear_ptr_d;
    logic [63:0]    mem_q [WORDS];

    logic           accept;
    logic           req_err;
    logic [2:0]     lane;
    logic [WAW-1:0] widx;
    logic [64:0]    end_addr;
    logic [7:0]     be_base;
    logic [7:0]     be;
    logic [63:0]    wdata_sh;
    logic [63:0]    rd_raw;

    assign accept   = bus.req_valid & bus.req_ready;
    assign lane     = bus.req_addr[2:0];
    assign widx     = bus.req_addr[WAW+2:3];
    assign end_addr = {1'b0, bus.req_addr} + 65'(size_mask(bus.req_size)) + 65'd1;
    assign req_err  = is_misaligned(bus.req_addr[2:0], bus.req_size)
                    | (end_addr > 65'(DEPTH_BYTES));

    always_comb begin
        be_base = 8'h01;
        case (bus.req_size)
            SZ_B:    be_base = 8'h01;
            SZ_H:    be_base = 8'h03;
            SZ_W:    be_base = 8'h0F;
            default: be_base = 8'hFF;
        endcase
    end

    // Aligned accesses never straddle a 64-bit word, so a lane shift suffices.
    assign be       = be_base << lane;
    assign wdata_sh = bus.req_wdata << {lane, 3'b000};
    assign rd_raw   = mem_q[widx] >> {lane, 3'b000};

    always_comb begin
        state_d     = state_q;
        clear_ptr_d = clear_ptr_q;
        case (state_q)
            ST_CLEAR: begin
                clear_ptr_d = clear_ptr_q + WAW'(1);
                if (clear_ptr_q == WAW'(WORDS - 1)) begin
                    clear_ptr_d = '0;
                    state_d     = ST_RUN;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_CLEAR;
            clear_ptr_q <= '0;
        end else begin
            state_q     <= state_d;
            clear_ptr_q <= clear_ptr_d;
        end
    end

    assign bus.req_ready = (state_q == ST_RUN) & ~reset;

    always_ff @(posedge clk) begin
        if (state_q == ST_CLEAR) begin
            mem_q[clear_ptr_q] <= '0;
        end else if (accept && bus.req_write && !req_err) begin
            for (int k = 0; k < 8; k++) begin
                if (be[k]) mem_q[widx][8*k +: 8] <= wdata_sh[8*k +: 8];
            end
        end
    end

    // Read pipeline: p0 captures memory at acceptance; p1/p2 add latency.
    logic      vld_p0_q, vld_p1_q, vld_p2_q;
    rd_stage_t rd_p0_q, rd_p1_q, rd_p2_q;
    logic      vld_fin;
    rd_stage_t rd_fin;
    logic [63:0] ext_data;

    always_ff @(posedge clk) begin
        if (reset) begin
            vld_p0_q <= 1'b0;
            vld_p1_q <= 1'b0;
            vld_p2_q <= 1'b0;
        end else begin
            vld_p0_q <= accept & (~bus.req_write | req_err);
            vld_p1_q <= vld_p0_q;
            vld_p2_q <= vld_p1_q;
        end
    end

    always_ff @(posedge clk) begin
        rd_p0_q <= '{err: req_err, size: bus.req_size, uns: bus.req_unsigned, raw: rd_raw};
        rd_p1_q <= rd_p0_q;
        rd_p2_q <= rd_p1_q;
    end

    always_comb begin
        vld_fin = vld_p0_q;
        rd_fin  = rd_p0_q;
        case (READ_LATENCY)
            1:       begin vld_fin = vld_p0_q; rd_fin = rd_p0_q; end
            2:       begin vld_fin = vld_p1_q; rd_fin = rd_p1_q; end
            default: begin vld_fin = vld_p2_q; rd_fin = rd_p2_q; end
        endcase
    end

    // Final stage
    dmem_load_extend u_ext (
        .raw_i      (rd_fin.raw),
        .size_i     (rd_fin.size),
        .unsigned_i (rd_fin.uns),
        .ext_o      (ext_data)
    );

    assign bus.rsp_valid = vld_fin;
    assign bus.rsp_err   = vld_fin & rd_fin.err;
    assign bus.rsp_rdata = (vld_fin & ~rd_fin.err) ? ext_data : '0;

`ifdef DMEM_PROBE_EN
    logic [8*NUM_PROBES-1:0] probe_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            probe_q <= '0;
        end else begin
            for (int k = 0; k < int'(NUM_PROBES); k++) begin
                probe_q[8*k +: 8] <=
                    mem_q[WAW'((PROBE_BASE + k*PROBE_STRIDE) >> 3)][8*((PROBE_BASE + k*PROBE_STRIDE) & 7) +: 8];
            end
        end
    end

    assign probe_data = probe_q;
`else
    assign probe_data = '0;
`endif

endmodule

// File: doc/dmem_ctrl.md
Name: dmem_ctrl

Overview:
- Parametrised, handshaked data memory for the pipelined RV64 core; it succeeds the fixed 8-byte combinational-read data memory.
- Supports B/H/W/D loads and stores with sign or zero extension, alignment and range checking, and a configurable registered read latency.
- Zeroes itself with a hardware clear sweep after reset.
- Exposes NUM_PROBES byte taps for board display.
- Sits in the MEM stage; the pipeline stalls on req_ready low.

Parameters:
- DEPTH_BYTES, 512: memory size in bytes; must be a multiple of 8.
- READ_LATENCY, 1: cycles from read acceptance to rsp_valid; legal range 1..3.
- NUM_PROBES, 4: number of 8-bit probe taps.
- PROBE_BASE, 256: byte address of probe 0.
- PROBE_STRIDE, 8: byte distance between consecutive probes.

Ports:
- clk, in, 1: clock; all logic is on the rising edge.
- reset, in, 1: synchronous, active-high reset.
- req_valid, in, 1: request present.
- req_ready, out, 1: request accepted when req_valid && req_ready.
- req_write, in, 1: 1 = store, 0 = load.
- req_size, in, 2: 0 = byte, 1 = half, 2 = word, 3 = double.
- req_unsigned, in, 1: zero-extend the load (lbu/lhu/lwu); ignored for stores.
- req_addr, in, 64: byte address.
- req_wdata, in, 64: store data; the low 8·2^size bits are used.
- rsp_valid, out, 1: load response or error strobe, one cycle wide.
- rsp_rdata, out, 64: extended load data; 0 when rsp_err is set.
- rsp_err, out, 1: misaligned or out-of-range request.
- probe_data, out, 8*NUM_PROBES: probe i = byte at PROBE_BASE + i*PROBE_STRIDE, in bits [8i+7:8i].

Behaviour:
- Byte order is little-endian: byte k of the datum lives at addr+k.
- State machine has two states, CLEAR and RUN.
  - reset forces CLEAR with clear_ptr = 0.
  - In CLEAR, one 8-byte word at clear_ptr*8 is zeroed per cycle; req_ready = 0.
  - After the last word (DEPTH_BYTES/8 − 1) the state goes to RUN.
  - req_ready = 1 in every RUN cycle.
- Reset values: req_ready 0, rsp_valid 0, rsp_rdata 0, rsp_err 0, the read pipeline is flushed, probe_data 0.
- Reset asserted during CLEAR restarts the sweep at word 0.
- Reset asserted with reads in flight drops them; no rsp_valid is ever produced for those reads.
- Error condition: addr[size-1:0] ≠ 0 (misaligned), or addr + 2^size > DEPTH_BYTES (out of range).
- An erroring request never modifies memory.
- An erroring request produces rsp_valid = 1 and rsp_err = 1 exactly READ_LATENCY cycles after acceptance, for loads and stores alike.
- Stores:
  - Bytes are written at the acceptance edge.
  - A valid store produces no response.
- Loads:
  - Memory is sampled at the acceptance edge.
  - The result is carried through READ_LATENCY − 1 further register stages; rsp_valid is asserted exactly READ_LATENCY cycles after acceptance.
  - Extension uses bit 8·2^size − 1, unless req_unsigned is set; for size 3, req_unsigned is ignored.
- Ordering: a store accepted at cycle N is visible to a load accepted at N+1. Back-to-back loads give one response per cycle.
- There is no backpressure on the response side; the consumer must accept rsp_valid unconditionally.
- probe_data is registered and follows memory writes with one cycle of delay.

Optional Feature:
- DMEM_PROBE_EN defined: probe_data is driven as described above.
- DMEM_PROBE_EN undefined: probe_data is a constant 0 and the probe registers are not built. The port list is unchanged.

Decomposition:
- Package dmem_pkg holds:
  - the size encoding enum (SZ_B, SZ_H, SZ_W, SZ_D);
  - a function returning the byte-count mask for a size;
  - the function is_misaligned(addr, size).
- One combinational sub-module, dmem_load_extend (inputs: raw 64-bit word, size, unsigned; output: extended 64-bit result), is instantiated at the final read stage.

Test Plan:
- Clear sweep: release reset → req_ready stays 0 for exactly 64 cycles (DEPTH_BYTES 512), then goes to 1. A ld at 0x100 then returns 0 after READ_LATENCY cycles.
- Store/load sizes and extension:
  - sd 0x80F0_E0D0_C0B0_A090 @0x40, then lb @0x47 → 0xFFFF_FFFF_FFFF_FF80.
  - lbu @0x47 → 0x80.
  - lh @0x46 → 0xFFFF_FFFF_FFFF_80F0.
  - lw @0x40 → 0xFFFF_FFFF_C0B0_A090.
- Read-after-write: sw 0x1234_5678 @0x8 at cycle N, lwu @0x8 at N+1 → 0x1234_5678. With READ_LATENCY=3, rsp_valid appears at N+4.
- Errors:
  - lw @0x42 → rsp_err = 1, rsp_rdata = 0.
  - sd @0x1FC with DEPTH 512 → rsp_err = 1, and a subsequent ld @0x1F8 is unchanged.
- Probes (DMEM_PROBE_EN on): sb 0x5A @264 → probe_data[15:8] = 0x5A one cycle after the store edge. With the macro off, the value stays 0.
- Reset mid-flight: accept two loads, assert reset the next cycle → no rsp_valid is observed, and the clear sweep restarts from word 0.
